// File: rtl/lstm_pkg.sv
// Shared fixed-point helpers and FSM encoding for the LSTM cell-state / hidden-output update.
package lstm_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  function automatic longint sat_max(input int bw);
    return (longint'(1) <<< (bw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bw);
    return -(longint'(1) <<< (bw - 1));
  endfunction

  // num * 2^(qm - frac_shift): e.g. (5,1) is 2.5, (3,3) is 0.375
  function automatic longint fx_const(input int num, input int frac_shift, input int qm);
    return longint'(num) <<< (qm - frac_shift);
  endfunction

  function automatic longint fx_one(input int qm);      return fx_const(1, 0, qm); endfunction
  function automatic longint fx_half(input int qm);     return fx_const(1, 1, qm); endfunction
  function automatic longint fx_two_half(input int qm); return fx_const(5, 1, qm); endfunction
  function automatic longint fx_c0375(input int qm);    return fx_const(3, 3, qm); endfunction

endpackage

// File: rtl/lstm_cell_update_fx_mul_sat.sv
// Signed fixed-point multiply, arithmetic shift by QM (floor), saturate to BITWIDTH. Purely combinational.
module fx_mul_sat
  import lstm_pkg::*;
#(
  parameter int BITWIDTH = 18,
  parameter int QM       = 11
) (
  input  logic signed [BITWIDTH-1:0] a_i,
  input  logic signed [BITWIDTH-1:0] b_i,
  output logic signed [BITWIDTH-1:0] y_o
);
  localparam int PW = 2 * BITWIDTH;
  localparam logic signed [PW-1:0] MAX_P = PW'(sat_max(BITWIDTH));
  localparam logic signed [PW-1:0] MIN_P = PW'(sat_min(BITWIDTH));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  always_comb begin
    prod    = $signed({{BITWIDTH{a_i[BITWIDTH-1]}}, a_i}) * $signed({{BITWIDTH{b_i[BITWIDTH-1]}}, b_i});
    shifted = prod >>> QM;
    if (shifted > MAX_P)      y_o = MAX_P[BITWIDTH-1:0];
    else if (shifted < MIN_P) y_o = MIN_P[BITWIDTH-1:0];
    else                      y_o = shifted[BITWIDTH-1:0];
  end
endmodule

// File: rtl/lstm_cell_update.sv
// LSTM element-wise update: c = sat(f*c_prev + i*g), h = sat(o*ptanh(c)), one element per cycle
// through a 3-stage pipeline sharing three multipliers; dataReady HIDDEN_SZ+4 edges after beginCalc.
module lstm_cell_update
  import lstm_pkg::*;
#(
  parameter  int HIDDEN_SZ      = 32,
  parameter  int QN             = 6,
  parameter  int QM             = 11,
  localparam int BITWIDTH       = bitwidth(QN, QM),
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      beginCalc,
  input  logic [LAYER_BITWIDTH-1:0] inputGate,
  input  logic [LAYER_BITWIDTH-1:0] forgetGate,
  input  logic [LAYER_BITWIDTH-1:0] candGate,
  input  logic [LAYER_BITWIDTH-1:0] outputGate,
  input  logic [LAYER_BITWIDTH-1:0] prevCell,
  output logic [LAYER_BITWIDTH-1:0] cellState,
  output logic [LAYER_BITWIDTH-1:0] hiddenOut,
  output logic                      dataReady,
  output logic                      busy
);
  localparam int BW  = BITWIDTH;
  localparam int BW1 = BITWIDTH + 1;
  localparam int CW  = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(HIDDEN_SZ - 1);
  localparam logic signed [BW1-1:0] SUM_MAX = BW1'(sat_max(BW));
  localparam logic signed [BW1-1:0] SUM_MIN = BW1'(sat_min(BW));
  localparam logic signed [BW1-1:0] ONE_W   = BW1'(fx_one(QM));
  localparam logic signed [BW1-1:0] HALF_W  = BW1'(fx_half(QM));
  localparam logic signed [BW1-1:0] TWOH_W  = BW1'(fx_two_half(QM));
  localparam logic signed [BW1-1:0] C0375_W = BW1'(fx_c0375(QM));

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    drain_q, drain_d;
  logic          rdy_q, rdy_d, busy_q, busy_d;
  logic          start;

  logic [LAYER_BITWIDTH-1:0] i_q, f_q, g_q, o_q, cp_q, cell_q, hid_q;

  logic signed [BW-1:0] f_k, cp_k, i_k, g_k, o_k;
  logic signed [BW-1:0] p_fc, p_ig, h_prod;

  logic                 v1_q, v2_q;
  logic [CW-1:0]        idx1_q, idx2_q;
  logic signed [BW-1:0] p_fc_q, p_ig_q, o1_q, o2_q, tanh2_q;

  logic signed [BW1-1:0] c_wide, c_abs;
  logic signed [BW-1:0]  c_sat, t_mag, tanh_c;

  assign start = beginCalc && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end
      end
      default: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'd2) state_d = ST_DONE;
      end
    endcase
    rdy_d = rdy_q;
    if (start)                 rdy_d = 1'b0;
    else if (state_q == ST_DONE) rdy_d = 1'b1;
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  // Operand select for the element currently entering S1
  always_comb begin
    f_k  = f_q[cnt_q*BW +: BW];
    cp_k = cp_q[cnt_q*BW +: BW];
    i_k  = i_q[cnt_q*BW +: BW];
    g_k  = g_q[cnt_q*BW +: BW];
    o_k  = o_q[cnt_q*BW +: BW];
  end

  fx_mul_sat #(.BITWIDTH(BW), .QM(QM)) u_mul_fc (.a_i(f_k),  .b_i(cp_k),    .y_o(p_fc));
  fx_mul_sat #(.BITWIDTH(BW), .QM(QM)) u_mul_ig (.a_i(i_k),  .b_i(g_k),     .y_o(p_ig));
  fx_mul_sat #(.BITWIDTH(BW), .QM(QM)) u_mul_o  (.a_i(o2_q), .b_i(tanh2_q), .y_o(h_prod));

  // S2: saturating sum, then piecewise-linear tanh on the saturated cell value
  always_comb begin
    c_wide = $signed({p_fc_q[BW-1], p_fc_q}) + $signed({p_ig_q[BW-1], p_ig_q});
    if (c_wide > SUM_MAX)      c_sat = SUM_MAX[BW-1:0];
    else if (c_wide < SUM_MIN) c_sat = SUM_MIN[BW-1:0];
    else                       c_sat = c_wide[BW-1:0];
    c_abs = c_sat[BW-1] ? -$signed({c_sat[BW-1], c_sat}) : $signed({c_sat[BW-1], c_sat});
    if (c_abs < HALF_W)      t_mag = BW'(c_abs);
    else if (c_abs < TWOH_W) t_mag = BW'((c_abs >>> 2) + C0375_W);
    else                     t_mag = BW'(ONE_W);
    tanh_c = c_sat[BW-1] ? -t_mag : t_mag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      cell_q  <= '0;
      hid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      if (start) begin
        i_q  <= inputGate;
        f_q  <= forgetGate;
        g_q  <= candGate;
        o_q  <= outputGate;
        cp_q <= prevCell;
      end
      v1_q    <= (state_q == ST_RUN);
      idx1_q  <= cnt_q;
      p_fc_q  <= p_fc;
      p_ig_q  <= p_ig;
      o1_q    <= o_k;
      v2_q    <= v1_q;
      idx2_q  <= idx1_q;
      o2_q    <= o1_q;
      tanh2_q <= tanh_c;
      if (v1_q) cell_q[idx1_q*BW +: BW] <= c_sat;
      if (v2_q) hid_q[idx2_q*BW +: BW]  <= h_prod;
    end
  end

  assign cellState = cell_q;
  assign hiddenOut = hid_q;
  assign dataReady = rdy_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update with a golden fixed-point model and result scoreboard.
module tb_lstm_cell_update;
  localparam int N  = 32;
  localparam int BW = 18;
  localparam int LW = N * BW;

  logic          clock = 1'b0;
  logic          reset, beginCalc;
  logic [LW-1:0] inputGate, forgetGate, candGate, outputGate, prevCell;
  logic [LW-1:0] cellState, hiddenOut;
  logic          dataReady, busy;

  int checks   = 0;
  int failures = 0;

  int fa[N], ca[N], ia[N], ga[N], oa[N];
  logic [LW-1:0] exp_c, exp_h, prev_c;
  logic [LW-1:0] q_c[$], q_h[$];
  int lat;

  always #5 clock = ~clock;

  lstm_cell_update dut (
    .clock(clock), .reset(reset), .beginCalc(beginCalc),
    .inputGate(inputGate), .forgetGate(forgetGate), .candGate(candGate),
    .outputGate(outputGate), .prevCell(prevCell),
    .cellState(cellState), .hiddenOut(hiddenOut),
    .dataReady(dataReady), .busy(busy)
  );

  function automatic longint sat(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic longint mulq(input longint a, input longint b);
    return sat((a * b) >>> 11);
  endfunction

  function automatic longint ptanh(input longint x);
    longint ax, r;
    ax = (x < 0) ? -x : x;
    if (ax < 1024)      r = ax;
    else if (ax < 5120) r = (ax >> 2) + 768;
    else                r = 2048;
    return (x < 0) ? -r : r;
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic load_vectors();
    longint c, h;
    logic [BW-1:0] t;
    for (int k = 0; k < N; k++) begin
      c = sat(mulq(fa[k], ca[k]) + mulq(ia[k], ga[k]));
      h = mulq(oa[k], ptanh(c));
      t = c[BW-1:0];        exp_c[k*BW +: BW] = t;
      t = h[BW-1:0];        exp_h[k*BW +: BW] = t;
      t = BW'(fa[k]);       forgetGate[k*BW +: BW] = t;
      t = BW'(ca[k]);       prevCell[k*BW +: BW]   = t;
      t = BW'(ia[k]);       inputGate[k*BW +: BW]  = t;
      t = BW'(ga[k]);       candGate[k*BW +: BW]   = t;
      t = BW'(oa[k]);       outputGate[k*BW +: BW] = t;
    end
  endtask

  task automatic fill_uniform(input int f, input int cp, input int i, input int g, input int o);
    for (int k = 0; k < N; k++) begin
      fa[k] = f; ca[k] = cp; ia[k] = i; ga[k] = g; oa[k] = o;
    end
    load_vectors();
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      fa[k] = int'($urandom_range(0, 100000)) - 50000;
      ca[k] = int'($urandom_range(0, 100000)) - 50000;
      ia[k] = int'($urandom_range(0, 8192)) - 4096;
      ga[k] = int'($urandom_range(0, 20000)) - 10000;
      oa[k] = int'($urandom_range(0, 4096)) - 2048;
    end
    load_vectors();
  endtask

  // Called just after a falling edge; returns just after the falling edge following the sampling edge.
  task automatic launch(input bit push);
    if (push) begin
      q_c.push_back(exp_c);
      q_h.push_back(exp_h);
    end
    beginCalc = 1'b1;
    @(negedge clock);
    beginCalc = 1'b0;
  endtask

  task automatic wait_ready(input int start_edges, output int edges);
    edges = start_edges;
    while (dataReady !== 1'b1 && edges < 200) begin
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic check_done(input string tag);
    logic [LW-1:0] ec, eh;
    ec = '0; eh = '0;
    checks++;
    assert (q_c.size() > 0) else begin
      failures++;
      $error("FAIL %s_scoreboard: got=empty expected=entry", tag);
    end
    if (q_c.size() > 0) begin
      ec = q_c.pop_front();
      eh = q_h.pop_front();
    end
    chk({tag, "_cell"}, cellState, ec);
    chk({tag, "_hidden"}, hiddenOut, eh);
    chk({tag, "_busy_done"}, LW'(busy), LW'(0));
  endtask

  initial begin
    reset = 1'b1; beginCalc = 1'b0;
    inputGate = '0; forgetGate = '0; candGate = '0; outputGate = '0; prevCell = '0;
    exp_c = '0; exp_h = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_cell", cellState, '0);
    chk("reset_hidden", hiddenOut, '0);
    chk("reset_ready", LW'(dataReady), LW'(0));
    chk("reset_busy", LW'(busy), LW'(0));

    // Mid-range: c=0.75, h=0.5625
    fill_uniform(2048, 1024, 1024, 1024, 2048);
    launch(1);
    chk("a_busy_start", LW'(busy), LW'(1));
    chk("a_ready_start", LW'(dataReady), LW'(0));
    wait_ready(0, lat);
    chk("a_latency", LW'(lat), LW'(36));
    chk("a_c0_const", LW'(cellState[BW-1:0]), LW'(1536));
    chk("a_h0_const", LW'(hiddenOut[BW-1:0]), LW'(1152));
    check_done("a");

    // Positive saturation of the cell sum
    fill_uniform(2048, 81920, 2048, 81920, 1024);
    launch(1);
    wait_ready(0, lat);
    chk("b_latency", LW'(lat), LW'(36));
    chk("b_c_last_const", LW'(cellState[(N-1)*BW +: BW]), LW'(18'h1FFFF));
    chk("b_h_last_const", LW'(hiddenOut[(N-1)*BW +: BW]), LW'(1024));
    check_done("b");

    // Negative cell, tanh clamps to -1.0
    fill_uniform(2048, -6144, 0, 12345, 1024);
    launch(1);
    wait_ready(0, lat);
    chk("c_c0_const", LW'(cellState[BW-1:0]), LW'(18'h3E800));
    chk("c_h0_const", LW'(hiddenOut[BW-1:0]), LW'(18'h3FC00));
    check_done("c");

    // Per-element ramps catch index skew
    for (int k = 0; k < N; k++) begin
      fa[k] = 2048 - k * 64;
      ca[k] = k * 256 - 3000;
      ia[k] = k * 64;
      ga[k] = 1500 - k * 128;
      oa[k] = k * 64 - 1024;
    end
    load_vectors();
    launch(1);
    wait_ready(0, lat);
    chk("d_latency", LW'(lat), LW'(36));
    check_done("d");

    // beginCalc re-pulsed in RUN with new inputs must be ignored
    fill_random();
    launch(1);
    repeat (9) @(negedge clock);
    fill_random();
    beginCalc = 1'b1;
    @(negedge clock);
    beginCalc = 1'b0;
    wait_ready(10, lat);
    chk("e_latency", LW'(lat), LW'(36));
    check_done("e");

    // Reset mid-RUN clears everything, then a clean run
    fill_random();
    launch(0);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("r_cell", cellState, '0);
    chk("r_hidden", hiddenOut, '0);
    chk("r_ready", LW'(dataReady), LW'(0));
    chk("r_busy", LW'(busy), LW'(0));
    fill_random();
    launch(1);
    wait_ready(0, lat);
    chk("r2_latency", LW'(lat), LW'(36));
    check_done("r2");

    // Back-to-back: second beginCalc the cycle after dataReady
    fill_random();
    launch(1);
    wait_ready(0, lat);
    chk("f1_latency", LW'(lat), LW'(36));
    prev_c = exp_c;
    check_done("f1");
    fill_random();
    launch(1);
    chk("f2_ready_drop", LW'(dataReady), LW'(0));
    chk("f2_cell_held", cellState, prev_c);
    wait_ready(0, lat);
    chk("f2_latency", LW'(lat), LW'(36));
    check_done("f2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lstm_cell_update.md
LSTM_CELL_UPDATE -- requirements
Module: lstm_cell_update

Interface
REQ-001 Parameter HIDDEN_SZ, default 32, meaning number of hidden units (elements per vector).
REQ-002 Parameter QN, default 6, meaning integer bits of signed fixed-point word.
REQ-003 Parameter QM, default 11, meaning fractional bits; BITWIDTH = QN+QM+1, LAYER_BITWIDTH = BITWIDTH*HIDDEN_SZ.
REQ-004 clock  input  1  clock, all state on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 beginCalc  input  1  start pulse; latches all input vectors.
REQ-007 inputGate, forgetGate, candGate, outputGate  input  LAYER_BITWIDTH each  gate vectors i, f, g, o from upstream gate instances; element k at [k*BITWIDTH +: BITWIDTH].
REQ-008 prevCell  input  LAYER_BITWIDTH  previous cell state c_prev.
REQ-009 cellState  output  LAYER_BITWIDTH  new cell state c.
REQ-010 hiddenOut  output  LAYER_BITWIDTH  new hidden output h, fed back as next prevOutVec source.
REQ-011 dataReady  output  1  results valid.
REQ-012 busy  output  1  computation in progress.

Function
REQ-013 Per element k: c[k] = sat(f[k]*c_prev[k] + i[k]*g[k]); h[k] = sat(o[k]*ptanh(c[k])).
REQ-014 Product: full 2*BITWIDTH signed, arithmetic shift right QM (truncate toward -inf), saturate to BITWIDTH; sum: BITWIDTH+1 bits then saturate.
REQ-015 Saturation limits: +(2^(BITWIDTH-1))-1 and -(2^(BITWIDTH-1)).
REQ-016 ptanh(x), by |x|: <0.5 -> |x|; 0.5..<2.5 -> 0.25*|x|+0.375; >=2.5 -> 1.0; result carries sign of x; shifts only, no multiplier.
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; reset -> IDLE.
REQ-018 IDLE/DONE + beginCalc=1: capture all five input vectors into internal registers, clear element counter, -> RUN, dataReady=0, busy=1.
REQ-019 RUN: one element per cycle enters 3-stage pipeline (S1 two products, S2 sum/sat/ptanh, S3 o-product/sat); counter 0..HIDDEN_SZ-1; at HIDDEN_SZ-1 -> DRAIN.
REQ-020 DRAIN: 3 cycles flush; each S2/S3 result written into cellState/hiddenOut slot of its own index; then -> DONE.
REQ-021 DONE: dataReady=1, busy=0, outputs held stable until next beginCalc or reset.
REQ-022 Latency: dataReady rises exactly HIDDEN_SZ+4 rising edges after the edge sampling beginCalc (36 for default).
REQ-023 beginCalc while RUN/DRAIN ignored; input vectors changing after capture have no effect.
REQ-024 beginCalc in DONE: dataReady drops next cycle, outputs keep old values until overwritten element-wise.
REQ-025 Exactly 3 multipliers instantiated (2 in S1, 1 in S3), shared across elements.

Reset
REQ-026 reset=1 at any edge, including mid-RUN/DRAIN: state IDLE, counter 0, pipeline valids 0, cellState=0, hiddenOut=0, dataReady=0, busy=0; reset dominates beginCalc.

Structure
REQ-027 Shared package lstm_pkg holds BITWIDTH derivation, saturation limits, fixed-point 1.0/0.5/2.5/0.375 constants and FSM state encoding.
REQ-028 One sub-module fx_mul_sat (signed multiply, shift QM, saturate), instantiated 3 times; ptanh inline.

Verification (Q6.11, 1.0 = 2048)
REQ-029 All elements f=1.0, c_prev=0.5, i=0.5, g=0.5, o=1.0 -> c=1536 (0.75), h=1152 (0.5625), dataReady at edge 36.
REQ-030 c_prev=40.0, f=1.0, i=1.0, g=40.0, o=0.5 -> c=0x1FFFF (saturated), h=1024 (0.5).
REQ-031 c_prev=-3.0, f=1.0, i=0, o=0.5 -> c=-6144, h=-1024 (0x3FC00).
REQ-032 Distinct per-element values (k*64 ramps) -> each output slot matches golden model at its own index, no index skew.
REQ-033 beginCalc re-pulsed at cycle 10 of RUN -> ignored, dataReady still at edge 36; reset at cycle 20 -> all outputs 0, IDLE, next beginCalc runs clean.
REQ-034 Two back-to-back samples, second beginCalc one cycle after dataReady -> both match golden, dataReady low during second run.
